// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage stall controller.
package mem_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_e;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between ID/EX and IF/ID.
module load_use_detect
  import mem_ctrl_pkg::*;
(
  input  logic             id_ex_MemtoReg,
  input  logic [REG_W-1:0] id_ex_Rd,
  input  logic [REG_W-1:0] if_id_Rs1,
  input  logic [REG_W-1:0] if_id_Rs2,
  output logic             load_use
);
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = id_ex_MemtoReg && (id_ex_Rd != ZERO_REG) &&
                    ((id_ex_Rd == if_id_Rs1) || (id_ex_Rd == if_id_Rs2));
endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-stage request/ack sequencer with pipeline stall and load-use bubbling.
// Optional access timeout/fault tracking is enabled by defining MEM_TIMEOUT_EN.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_MemtoReg,
  input  logic             ex_mem_MemWrite,
  input  logic             id_ex_MemtoReg,
  input  logic [REG_W-1:0] id_ex_Rd,
  input  logic [REG_W-1:0] if_id_Rs1,
  input  logic [REG_W-1:0] if_id_Rs2,
  input  logic             dmem_ack,
  input  logic             fault_clr,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             stall_all,
  output logic             stall_front,
  output logic             flush_id_ex,
  output logic             wb_bubble,
  output logic             mem_fault,
  output logic             fault_sticky
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;
  logic   access, req_raw, is_fault, load_use;

  assign access   = ex_mem_MemtoReg | ex_mem_MemWrite;
  assign is_fault = (state_q == FAULT);

  load_use_detect u_lud (
    .id_ex_MemtoReg (id_ex_MemtoReg),
    .id_ex_Rd       (id_ex_Rd),
    .if_id_Rs1      (if_id_Rs1),
    .if_id_Rs2      (if_id_Rs2),
    .load_use       (load_use)
  );

`ifdef MEM_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
`else
  logic [CW-1:0] unused_cnt;
  logic          unused_cfg;
  assign unused_cnt = '0;
  assign unused_cfg = fault_clr;
`endif

  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_raw = access;
        if (access && !dmem_ack) begin
          state_d = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = CW'(1);
`endif
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem_ack) state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) state_d = FAULT;
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      // FAULT lasts exactly one cycle; ack is ignored and no request is driven.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef MEM_TIMEOUT_EN
  // Setting from FAULT takes priority over a same-cycle clear.
  assign sticky_d = is_fault | (sticky_q & ~fault_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign mem_fault    = reset & is_fault;
  assign fault_sticky = reset & sticky_q;
`else
  assign mem_fault    = 1'b0;
  assign fault_sticky = 1'b0;
`endif

  // Everything is gated by reset so an in-flight request drops asynchronously.
  assign dmem_req    = reset & req_raw;
  assign dmem_we     = dmem_req & ex_mem_MemWrite;
  assign stall_all   = dmem_req & ~dmem_ack;
  assign wb_bubble   = stall_all | (reset & is_fault);
  assign stall_front = reset & load_use & ~stall_all;
  assign flush_id_ex = reset & load_use & ~stall_all;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed-vector bench for mem_stall_ctrl; checks all outputs as one packed word.
module tb_mem_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       ex_mem_MemtoReg, ex_mem_MemWrite, id_ex_MemtoReg;
  logic [4:0] id_ex_Rd, if_id_Rs1, if_id_Rs2;
  logic       dmem_ack, fault_clr;
  logic       dmem_req, dmem_we, stall_all, stall_front, flush_id_ex;
  logic       wb_bubble, mem_fault, fault_sticky;

  int nvec = 0;
  int nmis = 0;

  mem_stall_ctrl #(.TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_mem_MemtoReg (ex_mem_MemtoReg),
    .ex_mem_MemWrite (ex_mem_MemWrite),
    .id_ex_MemtoReg  (id_ex_MemtoReg),
    .id_ex_Rd        (id_ex_Rd),
    .if_id_Rs1       (if_id_Rs1),
    .if_id_Rs2       (if_id_Rs2),
    .dmem_ack        (dmem_ack),
    .fault_clr       (fault_clr),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .stall_all       (stall_all),
    .stall_front     (stall_front),
    .flush_id_ex     (flush_id_ex),
    .wb_bubble       (wb_bubble),
    .mem_fault       (mem_fault),
    .fault_sticky    (fault_sticky)
  );

  always #5 clk = ~clk;

  // {req, we, stall_all, stall_front, flush, wb_bubble, mem_fault, sticky}
  logic [7:0] outs;
  assign outs = {dmem_req, dmem_we, stall_all, stall_front, flush_id_ex,
                 wb_bubble, mem_fault, fault_sticky};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic ld, input logic st, input logic ack);
    ex_mem_MemtoReg = ld;
    ex_mem_MemWrite = st;
    dmem_ack        = ack;
  endtask

  task automatic set_lu(input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    id_ex_MemtoReg = ld;
    id_ex_Rd       = rd;
    if_id_Rs1      = rs1;
    if_id_Rs2      = rs2;
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    fault_clr = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);
    set_lu(1'b1, 5'd4, 5'd4, 5'd0);
    #2 chk("reset_gating", outs, 8'b0000_0000);
    cyc();
    chk("reset_hold", outs, 8'b0000_0000);
    set_in(1'b0, 1'b0, 1'b0);
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    #1 chk("post_reset_idle", outs, 8'b0000_0000);

    // Load acked in its request cycle: no stall.
    cyc(); set_in(1'b1, 1'b0, 1'b1);
    #1 chk("load_ack0", outs, 8'b1000_0000);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("load_ack0_done", outs, 8'b0000_0000);

    // Store acked after 3 wait cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(1'b0, 1'b1, 1'b0);
      #1 chk($sformatf("store_wait%0d", i), outs, 8'b1110_0100);
    end
    cyc(); set_in(1'b0, 1'b1, 1'b1);
    #1 chk("store_ack", outs, 8'b1100_0000);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("store_idle", outs, 8'b0000_0000);

    // Load-use detection.
    set_lu(1'b1, 5'd5, 5'd1, 5'd5);
    #1 chk("lu_rs2", outs, 8'b0001_1000);
    set_lu(1'b1, 5'd7, 5'd7, 5'd2);
    #1 chk("lu_rs1", outs, 8'b0001_1000);
    set_lu(1'b1, 5'd0, 5'd0, 5'd0);
    #1 chk("lu_rd0", outs, 8'b0000_0000);
    set_lu(1'b0, 5'd5, 5'd5, 5'd5);
    #1 chk("lu_not_load", outs, 8'b0000_0000);
    set_lu(1'b1, 5'd6, 5'd1, 5'd2);
    #1 chk("lu_nomatch", outs, 8'b0000_0000);
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: 8 request cycles, then FAULT with ack ignored.
    for (int i = 0; i < 8; i++) begin
      cyc(); set_in(1'b1, 1'b0, 1'b0);
      #1 chk($sformatf("to_req%0d", i), outs, 8'b1010_0100);
    end
    cyc(); set_in(1'b1, 1'b0, 1'b1);
    #1 chk("to_fault", outs, 8'b0000_0110);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("to_sticky", outs, 8'b0000_0001);
    fault_clr = 1'b1;
    #1 chk("to_clr_cycle", outs, 8'b0000_0001);
    cyc(); fault_clr = 1'b0;
    #1 chk("to_cleared", outs, 8'b0000_0000);
    // Clear coincident with FAULT: set wins.
    for (int i = 0; i < 8; i++) begin
      cyc(); set_in(1'b1, 1'b0, 1'b0);
    end
    cyc(); set_in(1'b0, 1'b0, 1'b0); fault_clr = 1'b1;
    #1 chk("to_fault2", outs, 8'b0000_0110);
    cyc(); fault_clr = 1'b0;
    #1 chk("to_set_wins", outs, 8'b0000_0001);
    fault_clr = 1'b1;
    cyc(); fault_clr = 1'b0;
    #1 chk("to_cleared2", outs, 8'b0000_0000);
`else
    // No timeout: the stall persists indefinitely until ack.
    for (int i = 0; i < 50; i++) begin
      cyc(); set_in(1'b1, 1'b0, 1'b0);
      #1 chk($sformatf("nto_wait%0d", i), outs, 8'b1010_0100);
    end
    cyc(); set_in(1'b1, 1'b0, 1'b1);
    #1 chk("nto_ack", outs, 8'b1000_0000);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("nto_idle", outs, 8'b0000_0000);
`endif

    // Memory stall outranks load-use; bubble appears once acked.
    set_lu(1'b1, 5'd3, 5'd3, 5'd9);
    for (int i = 0; i < 2; i++) begin
      cyc(); set_in(1'b0, 1'b1, 1'b0);
      #1 chk($sformatf("prio_stall%0d", i), outs, 8'b1110_0100);
    end
    cyc(); set_in(1'b0, 1'b1, 1'b1);
    #1 chk("prio_ack", outs, 8'b1101_1000);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("prio_lu", outs, 8'b0001_1000);
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);

    // Reset during the 2nd WAIT cycle aborts the access.
    cyc(); set_in(1'b1, 1'b0, 1'b0);
    #1 chk("rst_req", outs, 8'b1010_0100);
    cyc();
    #1 chk("rst_wait1", outs, 8'b1010_0100);
    cyc(); reset = 1'b0;
    #1 chk("rst_async", outs, 8'b0000_0000);
    cyc(); set_in(1'b0, 1'b0, 1'b0); reset = 1'b1;
    #1 chk("rst_idle", outs, 8'b0000_0000);
    cyc(); set_in(1'b1, 1'b0, 1'b1);
    #1 chk("rst_next_access", outs, 8'b1000_0000);
    cyc(); set_in(1'b0, 1'b0, 1'b0);
    #1 chk("rst_final", outs, 8'b0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
